// File: rtl/seq_fixmul.sv
// Iterative signed Q(WIDTH-FRAC_BITS).FRAC_BITS multiplier: sign-magnitude shift-add, one bit/cycle.
// Define SEQ_FIXMUL_SATURATE_EN to clamp overflowed results instead of wrapping.
module seq_fixmul #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAC_BITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned AccW = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [AccW-1:0] NegMax = AccW'(1) << (WIDTH - 1);
  localparam logic [AccW-1:0] PosMax = NegMax - AccW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e            state_q;
  logic [AccW-1:0]   mcand_q;
  logic [AccW-1:0]   acc_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [CntW-1:0]   cnt_q;
  logic              neg_q;

  logic [WIDTH-1:0]  abs_a;
  logic [WIDTH-1:0]  abs_b;
  logic [AccW-1:0]   mag;
  logic [WIDTH-1:0]  wrapped;
  logic [WIDTH-1:0]  fix_result;
  logic              fix_overflow;

  always_comb begin
    abs_a        = a[WIDTH-1] ? -a : a;
    abs_b        = b[WIDTH-1] ? -b : b;
    mag          = acc_q >> FRAC_BITS;
    fix_overflow = neg_q ? (mag > NegMax) : (mag > PosMax);
    // Negating a zero magnitude yields zero, so -0 never appears.
    wrapped      = neg_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
`ifdef SEQ_FIXMUL_SATURATE_EN
    if (fix_overflow) begin
      fix_result = neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      fix_result = wrapped;
    end
`else
    fix_result   = wrapped;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, abs_a};
            mplier_q <= abs_b;
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          // WIDTH shift-add steps, then one cycle to hand off, giving done after edge WIDTH+2.
          if (cnt_q == CntW'(WIDTH)) begin
            state_q <= StFix;
          end else begin
            if (mplier_q[0]) begin
              acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        StFix: begin
          result   <= fix_result;
          overflow <= fix_overflow;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_q  <= StDone;
        end
        StDone: begin
          if (!start) begin
            done    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_fixmul.sv
// Scoreboard bench for seq_fixmul: expected products queued at start, compared at done.
module tb_seq_fixmul;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned FRAC_BITS = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             overflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [16:0] exp_q[$];  // {overflow, result}

  seq_fixmul #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
    longint    p;
    longint    m;
    logic      neg;
    logic      ovf;
    logic [15:0] r;
    p   = longint'($signed(x)) * longint'($signed(y));
    neg = x[15] ^ y[15];
    m   = (p < 0 ? -p : p) >>> FRAC_BITS;
    ovf = neg ? (m > 32768) : (m > 32767);
    r   = neg ? 16'(-m) : 16'(m);
`ifdef SEQ_FIXMUL_SATURATE_EN
    if (ovf) r = neg ? 16'h8000 : 16'h7FFF;
`endif
    return {ovf, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int hold,
                        input bit drop_early, input string tag);
    logic [16:0] e;
    logic [15:0] res_seen;
    int          lat;
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    tick();
    if (drop_early) start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd18);
    check({tag, "_excl"}, {31'd0, done & busy}, 32'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1_ffff;
    check({tag, "_result"}, {16'd0, result}, {16'd0, e[15:0]});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e[16]});
    res_seen = result;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_done"}, {31'd0, done}, 32'd1);
      check({tag, "_hold_res"}, {16'd0, result}, {16'd0, res_seen});
    end
    start = 1'b0;
    tick();
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_res"}, {16'd0, result}, {16'd0, res_seen});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_flags", {29'd0, done, busy, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    run_op(16'h0040, 16'h0060, 5, 1'b0, "mul_2x3");
    run_op(16'hFFD0, 16'h0040, 0, 1'b0, "mul_n15x2");
    run_op(16'hFFB0, 16'hFF80, 0, 1'b1, "mul_n25xn4");
    run_op(16'h0001, 16'h0001, 0, 1'b0, "mul_tiny");
    run_op(16'hFFFF, 16'h0001, 0, 1'b0, "mul_negtiny");
    run_op(16'h4000, 16'h1000, 2, 1'b0, "mul_ovf");
    run_op(16'h8000, 16'h0020, 0, 1'b0, "mul_min");
    run_op(16'h8000, 16'hFFE0, 0, 1'b0, "mul_min_neg");
    run_op(16'h0000, 16'hFFFF, 0, 1'b0, "mul_zero");
    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom), 16'($urandom), 1, 1'b0, "mul_rand");
    end

    // Abort mid-operation with an asynchronous reset.
    a     = 16'h0123;
    b     = 16'h0456;
    start = 1'b1;
    tick();
    repeat (8) tick();
    check("abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_flags", {29'd0, done, busy, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(16'h0050, 16'hFFA0, 1, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
